// File: rtl/texture_mapper_mult_round_sat_if.sv
// texture_mapper_mult_round_sat_if
//  Valid/ready bundle between the multiplier core, the rescaling stage and
//  the downstream consumer.
//  in_valid/in_ready/in_product : upstream product handshake
//  out_valid/out_ready          : downstream result handshake
//  out_data/out_sat             : rescaled result and its clamp flag
//  master modport is the side that drives products and accepts results,
//  slave modport is the rescaling stage itself.
interface texture_mapper_mult_round_sat_if #(
  parameter int WIDTHP = 64,
  parameter int WIDTHO = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTHP-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTHO-1:0] out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/texture_mapper_mult_round_sat.sv
// texture_mapper_mult_round_sat
//  Rescales the multiplier's full-width fixed-point product: round half up,
//  arithmetic shift right by FRAC, clamp to WIDTHO bits. Results are held in
//  a 2-entry skid FIFO and a sticky saturation counter tracks clamped inputs.
//  Ports:
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   bus        : valid/ready product input and result output (slave side)
//   sat_clr    : synchronous clear of sat_count
//   sat_count  : number of accepted inputs that saturated, sticks at 16'hFFFF
module texture_mapper_mult_round_sat #(
  parameter int    WIDTHP         = 64,
  parameter int    WIDTHO         = 32,
  parameter int    FRAC           = 16,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  texture_mapper_mult_round_sat_if.slave        bus,
  input  logic                                  sat_clr,
  output logic [15:0]                           sat_count
);

  localparam bit IS_SIGNED = (REPRESENTATION == "SIGNED");
  localparam int RND_SHIFT = (FRAC > 0) ? (FRAC - 1) : 0;
  localparam logic [WIDTHP:0] RND_ONE = {{WIDTHP{1'b0}}, 1'b1};
  // Half an output LSB; zero when no fractional bits are dropped.
  localparam logic [WIDTHP:0] RND = (FRAC > 0) ? (RND_ONE << RND_SHIFT) : {(WIDTHP+1){1'b0}};

  logic signed [WIDTHP:0] ext_s;
  logic signed [WIDTHP:0] rnd_s;
  logic signed [WIDTHP:0] shf_s;
  logic [WIDTHO-1:0]      res_data_s;
  logic                   res_sat_s;

  logic [WIDTHO-1:0] e0_data_r;
  logic              e0_sat_r;
  logic [WIDTHO-1:0] e1_data_r;
  logic              e1_sat_r;
  logic [1:0]        cnt_r;
  logic [1:0]        cnt_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [15:0]       sat_count_r;
  logic              push_s;
  logic              pop_s;

  assign push_s = bus.in_valid & in_ready_r;
  assign pop_s  = out_valid_r & bus.out_ready;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = e0_data_r;
  assign bus.out_sat   = e0_sat_r;
  assign sat_count     = sat_count_r;

  // Round, shift and clamp the incoming product.
  always_comb begin
    ext_s      = {(IS_SIGNED ? bus.in_product[WIDTHP-1] : 1'b0), bus.in_product};
    // One extra MSB means the rounding add can never wrap.
    rnd_s      = ext_s + $signed(RND);
    shf_s      = rnd_s >>> FRAC;
    res_data_s = shf_s[WIDTHO-1:0];
    res_sat_s  = 1'b0;
    if (IS_SIGNED) begin
      // In range only when every bit above the output sign bit matches it.
      if (!((&shf_s[WIDTHP:WIDTHO-1]) || !(|shf_s[WIDTHP:WIDTHO-1]))) begin
        res_sat_s  = 1'b1;
        res_data_s = shf_s[WIDTHP] ? {1'b1, {(WIDTHO-1){1'b0}}}
                                   : {1'b0, {(WIDTHO-1){1'b1}}};
      end else begin
        res_sat_s  = 1'b0;
      end
    end else begin
      if (|shf_s[WIDTHP:WIDTHO]) begin
        res_sat_s  = 1'b1;
        res_data_s = {WIDTHO{1'b1}};
      end else begin
        res_sat_s  = 1'b0;
      end
    end
  end

  // Next FIFO occupancy from the two handshakes.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (push_s && !pop_s) begin
      cnt_nxt_s = cnt_r + 2'd1;
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = cnt_r - 2'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Skid FIFO storage; entry 0 is always the head shown on the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_data_r   <= {WIDTHO{1'b0}};
      e0_sat_r    <= 1'b0;
      e1_data_r   <= {WIDTHO{1'b0}};
      e1_sat_r    <= 1'b0;
      cnt_r       <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (cnt_r)
        2'd0: begin
          if (push_s) begin
            e0_data_r <= res_data_s;
            e0_sat_r  <= res_sat_s;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            e0_data_r <= res_data_s;
            e0_sat_r  <= res_sat_s;
          end else if (push_s) begin
            e1_data_r <= res_data_s;
            e1_sat_r  <= res_sat_s;
          end
        end
        2'd2: begin
          if (pop_s) begin
            e0_data_r <= e1_data_r;
            e0_sat_r  <= e1_sat_r;
          end
        end
        default: begin
          e0_data_r <= e0_data_r;
        end
      endcase
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (cnt_nxt_s != 2'd2);
      out_valid_r <= (cnt_nxt_s != 2'd0);
    end
  end

  // Sticky saturation counter; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count_r <= 16'd0;
    end else if (sat_clr) begin
      sat_count_r <= 16'd0;
    end else if (push_s && res_sat_s && (sat_count_r != 16'hFFFF)) begin
      sat_count_r <= sat_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_texture_mapper_mult_round_sat.sv
module tb_texture_mapper_mult_round_sat;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sat_clr_u;
  logic        sat_clr_s;
  logic [15:0] sat_count_u;
  logic [15:0] sat_count_s;

  int   tests;
  int   fails;
  int   cyc;
  exp_t q_u[$];
  exp_t q_s[$];

  texture_mapper_mult_round_sat_if #(.WIDTHP(64), .WIDTHO(32)) bu ();
  texture_mapper_mult_round_sat_if #(.WIDTHP(64), .WIDTHO(32)) bs ();

  texture_mapper_mult_round_sat dut_u (
    .clk(clk), .reset_n(reset_n), .bus(bu), .sat_clr(sat_clr_u), .sat_count(sat_count_u)
  );

  texture_mapper_mult_round_sat #(.REPRESENTATION("SIGNED")) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bs), .sat_clr(sat_clr_s), .sat_count(sat_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Unsigned-instance monitor: compare head against scoreboard on each pop.
  always @(negedge clk) begin
    if (reset_n && bu.out_valid && bu.out_ready) begin
      if (q_u.size() == 0) begin
        check("u_unexpected_output", 64'(bu.out_data), 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        exp_t e;
        e = q_u.pop_front();
        check("u_data", 64'(bu.out_data), 64'(e.data));
        check("u_sat", 64'(bu.out_sat), 64'(e.sat));
        if (e.lat) check("u_latency", 64'(cyc), 64'(e.cyc + 1));
      end
    end
  end

  // Signed-instance monitor.
  always @(negedge clk) begin
    if (reset_n && bs.out_valid && bs.out_ready) begin
      if (q_s.size() == 0) begin
        check("s_unexpected_output", 64'(bs.out_data), 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        check("s_data", 64'(bs.out_data), 64'(e.data));
        check("s_sat", 64'(bs.out_sat), 64'(e.sat));
      end
    end
  end

  // Offer one product; expected result is queued on the accepting cycle.
  task automatic send(input bit sgn, input logic [63:0] p, input logic [31:0] d,
                      input logic s, input bit lat, output int waits);
    bit   done;
    exp_t e;
    waits = 0;
    done  = 1'b0;
    if (sgn) begin bs.in_valid = 1'b1; bs.in_product = p; end
    else     begin bu.in_valid = 1'b1; bu.in_product = p; end
    while (!done) begin
      @(negedge clk);
      if (sgn ? bs.in_ready : bu.in_ready) begin
        e.data = d; e.sat = s; e.cyc = cyc; e.lat = lat;
        if (sgn) q_s.push_back(e); else q_u.push_back(e);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          tests++; fails++;
          $display("FAIL accept_timeout: product %h not accepted in 50 cycles", p);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bu.in_valid = 1'b0;
    bs.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_u_empty", 64'(q_u.size()), 64'd0);
    check("drain_s_empty", 64'(q_s.size()), 64'd0);
  endtask

  initial begin
    int w;
    tests = 0; fails = 0; cyc = 0;
    reset_n = 1'b0;
    sat_clr_u = 1'b0; sat_clr_s = 1'b0;
    bu.in_valid = 1'b0; bu.in_product = 64'd0; bu.out_ready = 1'b1;
    bs.in_valid = 1'b0; bs.in_product = 64'd0; bs.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bu.out_valid), 64'd0);
    check("rst_in_ready", 64'(bu.in_ready), 64'd1);
    check("rst_out_data", 64'(bu.out_data), 64'd0);
    check("rst_out_sat", 64'(bu.out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count_u), 64'd0);
    @(posedge clk); #1;

    // Rounding
    send(1'b0, 64'h0000_0000_0003_8000, 32'h4, 1'b0, 1'b0, w);
    send(1'b0, 64'h0000_0000_0003_7FFF, 32'h3, 1'b0, 1'b0, w);
    send(1'b0, 64'h0000_FFFF_FFFF_7FFF, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
    check("sat_count_0", 64'(sat_count_u), 64'd0);
    // Unsigned saturation
    send(1'b0, 64'h0001_0000_0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    check("sat_count_1", 64'(sat_count_u), 64'd1);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    check("sat_count_2", 64'(sat_count_u), 64'd2);
    send(1'b0, 64'h0000_FFFF_FFFF_8000, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    check("sat_count_3", 64'(sat_count_u), 64'd3);
    idle();

    // Signed
    send(1'b1, 64'hFFFF_FFFF_FFFE_8000, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
    send(1'b1, 64'h8000_0000_0000_0000, 32'h8000_0000, 1'b1, 1'b0, w);
    send(1'b1, 64'h0000_7FFF_FFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, w);
    send(1'b1, 64'h0000_7FFF_FFFF_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, w);
    check("s_sat_count", 64'(sat_count_s), 64'd2);
    idle();
    drain();

    // Backpressure: A, B fill the FIFO, C is refused
    bu.out_ready = 1'b0;
    send(1'b0, 64'h0000_0000_0001_0000, 32'h1, 1'b0, 1'b0, w);
    send(1'b0, 64'h0000_0000_0002_0000, 32'h2, 1'b0, 1'b0, w);
    bu.in_valid = 1'b1; bu.in_product = 64'h0000_0000_0003_0000;
    @(negedge clk);
    check("bp_in_ready_full", 64'(bu.in_ready), 64'd0);
    check("bp_head_A", 64'(bu.out_data), 64'h1);
    @(posedge clk); #1;
    check("bp_head_stable", 64'(bu.out_data), 64'h1);
    bu.out_ready = 1'b1;
    send(1'b0, 64'h0000_0000_0003_0000, 32'h3, 1'b0, 1'b0, w);
    idle();
    drain();

    // Streaming: 100 consecutive beats, each rounds up to i+1
    for (int i = 0; i < 100; i++) begin
      send(1'b0, (64'(i) << 16) | 64'h8000, 32'(i + 1), 1'b0, 1'b1, w);
      check("stream_no_stall", 64'(w), 64'd0);
    end
    idle();
    drain();

    // Reset with two entries held
    bu.out_ready = 1'b0;
    send(1'b0, 64'h0000_0000_0005_0000, 32'h5, 1'b0, 1'b0, w);
    send(1'b0, 64'h0000_0000_0006_0000, 32'h6, 1'b0, 1'b0, w);
    idle();
    @(negedge clk);
    check("pre_rst_full", 64'(bu.in_ready), 64'd0);
    check("pre_rst_sat_count", 64'(sat_count_u), 64'd3);
    reset_n = 1'b0;
    q_u.delete();
    q_s.delete();
    #1;
    check("mid_rst_out_valid", 64'(bu.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bu.in_ready), 64'd1);
    check("mid_rst_sat_count", 64'(sat_count_u), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bu.out_ready = 1'b1;
    @(posedge clk); #1;

    // Saturating push with coincident clear is not counted
    send(1'b0, 64'h0000_0000_0001_0000, 32'h1, 1'b0, 1'b0, w);
    check("pre_clr_sat_count", 64'(sat_count_u), 64'd0);
    send(1'b0, 64'h0001_0000_0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    check("sat_count_after_sat", 64'(sat_count_u), 64'd1);
    sat_clr_u = 1'b1;
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
    sat_clr_u = 1'b0;
    check("clr_priority", 64'(sat_count_u), 64'd0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
